// File: rtl/apb_byte_mailbox.sv
// apb_byte_mailbox: APB slave exposing a TX and an RX byte FIFO as a buffered byte mailbox
// Ports:
//   clk, rst                       single clock; asynchronous active-high reset
//   psel/paddr/penable/pwrite/pwdata -> prdata/pready   zero-wait-state APB slave
//   tx_data/tx_valid <- tx_ready   byte stream out of the TX FIFO
//   rx_data/rx_valid -> rx_ready   byte stream into the RX FIFO
//   irq                            only when MAILBOX_IRQ_EN is defined (with IRQEN at 0x07)
module apb_byte_mailbox #(
    parameter int         DEPTH    = 8,
    parameter logic [7:0] ID_VALUE = 8'hB8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       psel,
    input  logic [4:0] paddr,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
`ifdef MAILBOX_IRQ_EN
    output logic       irq,
`endif
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [AW:0]   tx_cnt, rx_cnt;
    logic          tx_ovf, rx_udf, rx_hit;
    logic          setup, access, tx_wr, rx_rd, ctrl_wr;
    logic          flush_tx, flush_rx, clr;
    logic          tx_xfer, tx_push, tx_pop, rx_push, rx_pop, set_ovf, set_udf;
    logic [7:0]    status, rd_val;

    assign pready   = 1'b1;
    assign setup    = psel & ~penable;
    assign access   = psel & penable & pready;
    assign tx_wr    = access & pwrite & (paddr == 5'h02);
    assign rx_rd    = access & ~pwrite & (paddr == 5'h03);
    assign ctrl_wr  = access & pwrite & (paddr == 5'h04);
    assign flush_tx = ctrl_wr & pwdata[0];
    assign flush_rx = ctrl_wr & pwdata[1];
    assign clr      = ctrl_wr & pwdata[2];

    assign tx_valid = (tx_cnt != '0);
    assign tx_data  = tx_mem[tx_rp];
    assign tx_xfer  = tx_valid & tx_ready;
    assign tx_pop   = tx_xfer & ~flush_tx;
    assign tx_push  = tx_wr & ((tx_cnt != FULL) | tx_xfer) & ~flush_tx;
    assign set_ovf  = tx_wr & (tx_cnt == FULL) & ~tx_xfer & ~flush_tx;

    // rx_hit records whether RXDATA had a byte at setup; only then does the access pop
    assign rx_pop   = rx_rd & rx_hit & (rx_cnt != '0) & ~flush_rx;
    // a completing APB pop frees a slot, so a full RX FIFO still takes the inbound byte
    assign rx_ready = (rx_cnt != FULL) | rx_pop;
    assign rx_push  = rx_valid & rx_ready & ~flush_rx;
    assign set_udf  = rx_rd & ~rx_hit & ~flush_rx;

    assign status = {2'b00, rx_udf, tx_ovf, rx_cnt == '0, rx_cnt == FULL, tx_cnt == '0, tx_cnt == FULL};

`ifdef MAILBOX_IRQ_EN
    logic [2:0] irqen;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            irqen <= '0;
            irq   <= 1'b0;
        end else begin
            if (access & pwrite & (paddr == 5'h07)) irqen <= pwdata[2:0];
            irq <= |(irqen & {tx_ovf | rx_udf, tx_cnt == '0, rx_cnt != '0});
        end
`endif

    always_comb begin
        rd_val = '0;
        case (paddr)
            5'h00:   rd_val = ID_VALUE;
            5'h01:   rd_val = status;
            5'h03:   rd_val = (rx_cnt != '0) ? rx_mem[rx_rp] : 8'h00;
            5'h05:   rd_val = 8'(tx_cnt);
            5'h06:   rd_val = 8'(rx_cnt);
`ifdef MAILBOX_IRQ_EN
            5'h07:   rd_val = {5'b0, irqen};
`endif
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            prdata <= '0;
            rx_hit <= 1'b0;
            tx_ovf <= 1'b0;
            rx_udf <= 1'b0;
            tx_wp  <= '0;
            tx_rp  <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            tx_cnt <= '0;
            rx_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tx_mem[i] <= '0;
                rx_mem[i] <= '0;
            end
        end else begin
            if (setup) begin
                prdata <= rd_val;
                rx_hit <= (rx_cnt != '0);
            end
            if (tx_push) tx_mem[tx_wp] <= pwdata;
            if (rx_push) rx_mem[rx_wp] <= rx_data;
            tx_wp  <= flush_tx ? '0 : tx_wp + AW'(tx_push);
            tx_rp  <= flush_tx ? '0 : tx_rp + AW'(tx_pop);
            rx_wp  <= flush_rx ? '0 : rx_wp + AW'(rx_push);
            rx_rp  <= flush_rx ? '0 : rx_rp + AW'(rx_pop);
            tx_cnt <= flush_tx ? '0 : tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
            rx_cnt <= flush_rx ? '0 : rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
            // a flag-setting event outranks a same-cycle clear
            tx_ovf <= set_ovf | (tx_ovf & ~clr);
            rx_udf <= set_udf | (rx_udf & ~clr);
        end
endmodule

// File: tb/tb_apb_byte_mailbox.sv
// tb_apb_byte_mailbox: self-checking bench for apb_byte_mailbox (register table plus FIFO scoreboards)
module tb_apb_byte_mailbox;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [4:0] a;
        logic       w;
        logic [7:0] d;
        logic [7:0] e;
    } vec_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [4:0] paddr = '0;
    logic [7:0] pwdata = '0, rx_data = '0;
    logic       tx_ready = 1'b0, rx_valid = 1'b0;
    logic [7:0] prdata, tx_data;
    logic       pready, tx_valid, rx_ready;
`ifdef MAILBOX_IRQ_EN
    logic       irq;
`endif
    int         total = 0, bad = 0;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];

    always #5 clk = ~clk;

    apb_byte_mailbox #(.DEPTH(DEPTH), .ID_VALUE(8'hB8)) dut (
        .clk(clk), .rst(rst),
        .psel(psel), .paddr(paddr), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready),
`ifdef MAILBOX_IRQ_EN
        .irq(irq),
`endif
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    task automatic check(input string n, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // TX scoreboard: every stream transfer must match the oldest accepted write
    always @(negedge clk)
        if (!rst && tx_valid === 1'b1 && tx_ready) begin
            if (txq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL tx_extra: got %h expected no transfer", tx_data);
            end else check("tx_data", tx_data, txq.pop_front());
        end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic apb(input logic [4:0] a, input logic w, input logic [7:0] d, output logic [7:0] r);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        r = prdata;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        logic [7:0] r;
        if (a == 5'h02 && txq.size() < DEPTH) txq.push_back(d);
        if (a == 5'h04 && d[0]) txq.delete();
        if (a == 5'h04 && d[1]) rxq.delete();
        apb(a, 1'b1, d, r);
    endtask

    task automatic rd_chk(input logic [4:0] a, input logic [7:0] e, input string n);
        logic [7:0] r;
        apb(a, 1'b0, 8'h00, r);
        check(n, r, e);
    endtask

    task automatic rx_read(input string n);
        logic [7:0] e;
        if (rxq.size() != 0) e = rxq.pop_front();
        else e = 8'h00;
        rd_chk(5'h03, e, n);
    endtask

    task automatic rx_push(input logic [7:0] d);
        @(negedge clk);
        rx_data = d; rx_valid = 1'b1;
        check("rx_ready", rx_ready, 8'(rxq.size() < DEPTH));
        if (rxq.size() < DEPTH) rxq.push_back(d);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic drain(input string n);
        @(posedge clk);
        #1 tx_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && tx_valid; i++) @(negedge clk);
        check(n, tx_valid, 8'h00);
        check({n, "_left"}, 8'(txq.size()), 8'h00);
        @(posedge clk);
        #1 tx_ready = 1'b0;
    endtask

    task automatic rst_mid(input logic [4:0] a, input logic w, input logic [7:0] d);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; rst = 1'b0;
        txq.delete();
        rxq.delete();
    endtask

    initial begin
        vec_t tbl[12];
        tbl[0]  = '{5'h00, 1'b0, 8'h00, 8'hB8};
        tbl[1]  = '{5'h01, 1'b0, 8'h00, 8'h0A};
        tbl[2]  = '{5'h05, 1'b0, 8'h00, 8'h00};
        tbl[3]  = '{5'h06, 1'b0, 8'h00, 8'h00};
        tbl[4]  = '{5'h04, 1'b0, 8'h00, 8'h00};
        tbl[5]  = '{5'h02, 1'b0, 8'h00, 8'h00};
        tbl[6]  = '{5'h07, 1'b0, 8'h00, 8'h00};
        tbl[7]  = '{5'h1F, 1'b0, 8'h00, 8'h00};
        tbl[8]  = '{5'h00, 1'b1, 8'hFF, 8'h00};
        tbl[9]  = '{5'h1F, 1'b1, 8'h55, 8'h00};
        tbl[10] = '{5'h00, 1'b0, 8'h00, 8'hB8};
        tbl[11] = '{5'h01, 1'b0, 8'h00, 8'h0A};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_prdata", prdata, 8'h00);
        check("rst_pready", 8'(pready), 8'h01);
        check("rst_tx_valid", 8'(tx_valid), 8'h00);
        check("rst_rx_ready", 8'(rx_ready), 8'h01);
        check("rst_tx_data", tx_data, 8'h00);

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].w) wr(tbl[i].a, tbl[i].d);
            else rd_chk(tbl[i].a, tbl[i].e, $sformatf("vec%0d", i));
        end

        wr(5'h02, 8'h11);
        wr(5'h02, 8'h22);
        wr(5'h02, 8'h33);
        rd_chk(5'h05, 8'h03, "txcount3");
        check("tx_valid_on", 8'(tx_valid), 8'h01);
        check("tx_head", tx_data, 8'h11);
        @(negedge clk);
        check("tx_hold", tx_data, 8'h11);
        drain("tx_drain3");

        for (int i = 0; i < 9; i++) wr(5'h02, 8'h40 + 8'(i));
        rd_chk(5'h05, 8'h08, "txcount_full");
        rd_chk(5'h01, 8'h19, "status_ovf");
        wr(5'h04, 8'h04);
        rd_chk(5'h01, 8'h09, "status_ovf_clr");
        drain("tx_drain_ovf");
        rd_chk(5'h01, 8'h0A, "status_idle");

        rx_push(8'hA5);
        rx_push(8'h5A);
        rd_chk(5'h06, 8'h02, "rxcount2");
        rx_read("rx_first");
        rx_read("rx_second");
        rx_read("rx_empty_rd");
        rd_chk(5'h01, 8'h2A, "status_udf");
        wr(5'h04, 8'h04);
        rd_chk(5'h01, 8'h0A, "status_udf_clr");
        for (int i = 0; i < DEPTH; i++) rx_push(8'h80 + 8'(i));
        @(negedge clk);
        check("rx_ready_full", 8'(rx_ready), 8'h00);
        rx_push(8'hFF);
        rd_chk(5'h06, 8'h08, "rxcount_full");
        rd_chk(5'h01, 8'h06, "status_rx_full");

        @(negedge clk);
        psel = 1'b1; penable = 1'b0; paddr = 5'h03; pwrite = 1'b0;
        @(negedge clk);
        penable = 1'b1; rx_data = 8'hC3; rx_valid = 1'b1;
        #1 check("rx_ready_pop", 8'(rx_ready), 8'h01);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; rx_valid = 1'b0;
        check("rx_pop_data", prdata, rxq.pop_front());
        rxq.push_back(8'hC3);
        rd_chk(5'h06, 8'h08, "rxcount_swap");
        rx_read("rx_after_swap");

        @(negedge clk);
        psel = 1'b1; penable = 1'b0; paddr = 5'h04; pwrite = 1'b1; pwdata = 8'h02;
        @(negedge clk);
        penable = 1'b1; rx_data = 8'hEE; rx_valid = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; rx_valid = 1'b0;
        rxq.delete();
        rd_chk(5'h06, 8'h00, "rxcount_flush");
        rd_chk(5'h01, 8'h0A, "status_flush");

        rd_chk(5'h00, 8'hB8, "id_pre_rst");
        rst_mid(5'h00, 1'b0, 8'h00);
        check("rst_mid_prdata", prdata, 8'h00);
        wr(5'h02, 8'h66);
        check("tx_valid_pre", 8'(tx_valid), 8'h01);
        rst_mid(5'h02, 1'b1, 8'h77);
        check("rst_mid_tx_valid", 8'(tx_valid), 8'h00);
        check("rst_mid_prdata2", prdata, 8'h00);
        rd_chk(5'h05, 8'h00, "txcount_rst");

`ifdef MAILBOX_IRQ_EN
        check("irq_rst", 8'(irq), 8'h00);
        wr(5'h07, 8'h01);
        rd_chk(5'h07, 8'h01, "irqen_rd");
        check("irq_idle", 8'(irq), 8'h00);
        rx_push(8'h3C);
        check("irq_lag", 8'(irq), 8'h00);
        @(negedge clk);
        check("irq_rise", 8'(irq), 8'h01);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
